// File: rtl/word_serial_tx.sv
// word_serial_tx: parallel-in, serial-out transmitter for one WIDTH-bit word.
// Latency: first bit on q the cycle after the accept edge; done follows the last bit period.
// Backpressure: ready only in IDLE; load while busy is dropped; e=0 freezes the current bit.
//
// Ports:
//   clk   - clock, rising edge
//   r     - asynchronous active-high reset
//   e     - shift enable; each enabled edge ends one bit period
//   d     - parallel word, sampled only on the accept edge
//   load  - request to accept d (honoured when ready)
//   ready - high in IDLE
//   q     - registered serial data, idles high; qbar = ~q
//   busy  - high while a word (and optional parity bit) is being sent
//   done  - one-cycle pulse after the final bit period
//
// Optional feature: define WORD_SERIAL_TX_PARITY_EN to append an even-parity
// bit (XOR of the captured word) after the last data bit.
module word_serial_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             r,
  input  logic             e,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  output logic             ready,
  output logic             q,
  output logic             qbar,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef WORD_SERIAL_TX_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_q, ser_d;
  logic             done_q, done_d;
`ifdef WORD_SERIAL_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b1;
      done_q  <= 1'b0;
`ifdef WORD_SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
`ifdef WORD_SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
`ifdef WORD_SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        // Acceptance does not depend on e: the first bit is presented at once.
        if (load) begin
          state_d = SHIFT;
          sreg_d  = d;
          cnt_d   = '0;
          ser_d   = MSB_FIRST ? d[WIDTH-1] : d[0];
`ifdef WORD_SERIAL_TX_PARITY_EN
          par_d   = ^d;
`endif
        end
      end
      SHIFT: begin
        if (e) begin
          if (cnt_q == LAST) begin
`ifdef WORD_SERIAL_TX_PARITY_EN
            state_d = PARITY;
            ser_d   = par_q;
`else
            state_d = IDLE;
            ser_d   = 1'b1;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
            // Rotate rather than shift: the vacated bit is never transmitted,
            // and the register stays a plain ring of the captured word.
            if (MSB_FIRST) begin
              ser_d  = sreg_q[WIDTH-2];
              sreg_d = {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]};
            end else begin
              ser_d  = sreg_q[1];
              sreg_d = {sreg_q[0], sreg_q[WIDTH-1:1]};
            end
          end
        end
      end
`ifdef WORD_SERIAL_TX_PARITY_EN
      PARITY: begin
        if (e) begin
          state_d = IDLE;
          ser_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign q     = ser_q;
  assign qbar  = ~ser_q;
  assign done  = done_q;

endmodule

// File: tb/tb_word_serial_tx.sv
// Directed bench for word_serial_tx: one MSB-first and one LSB-first
// instance share all stimulus; each step checks the relevant instance.
module tb_word_serial_tx;

  logic       clk;
  logic       r;
  logic       e;
  logic [7:0] d;
  logic       load;
  logic       ready_m, q_m, qbar_m, busy_m, done_m;
  logic       ready_l, q_l, qbar_l, busy_l, done_l;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] pat;

  word_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .r(r), .e(e), .d(d), .load(load),
    .ready(ready_m), .q(q_m), .qbar(qbar_m), .busy(busy_m), .done(done_m)
  );

  word_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .r(r), .e(e), .d(d), .load(load),
    .ready(ready_l), .q(q_l), .qbar(qbar_l), .busy(busy_l), .done(done_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef WORD_SERIAL_TX_PARITY_EN
  task automatic end_word(input bit lsb, input logic par);
    e = 1'b1;
    chk("parity_bit", lsb ? q_l : q_m, par);
    chk("parity_busy", lsb ? busy_l : busy_m, 1'b1);
    chk("parity_no_done", lsb ? done_l : done_m, 1'b0);
    tick();
  endtask
`endif

  initial begin
    r = 1'b0; e = 1'b0; load = 1'b0; d = 8'h00;

    // Reset values visible without any clock edge.
    #2 r = 1'b1;
    #1;
    chk("rst_q", q_m, 1'b1);
    chk("rst_qbar", qbar_m, 1'b0);
    chk("rst_ready", ready_m, 1'b1);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_done", done_m, 1'b0);
    tick();
    tick();
    r = 1'b0;
    tick();

    // Basic MSB-first word; d changes after accept must not matter.
    pat = 8'hA5;
    d = pat; load = 1'b1; e = 1'b1;
    tick();
    load = 1'b0; d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk("a5_bit", q_m, pat[7-i]);
      chk("a5_qbar", qbar_m, ~pat[7-i]);
      chk("a5_busy", busy_m, 1'b1);
      chk("a5_no_done", done_m, 1'b0);
      tick();
    end
`ifdef WORD_SERIAL_TX_PARITY_EN
    end_word(1'b0, 1'b0);
`endif
    chk("a5_done", done_m, 1'b1);
    chk("a5_done_q", q_m, 1'b1);
    chk("a5_done_ready", ready_m, 1'b1);
    tick();
    chk("a5_done_pulse", done_m, 1'b0);

    // LSB-first with e toggling; accept happens with e low.
    pat = 8'h01;
    d = pat; load = 1'b1; e = 1'b0;
    tick();
    load = 1'b0;
    for (int c = 0; c < 16; c++) begin
      e = (c % 2 == 1);
      chk("lsb_bit", q_l, pat[c/2]);
      chk("lsb_no_done", done_l, 1'b0);
      tick();
    end
`ifdef WORD_SERIAL_TX_PARITY_EN
    end_word(1'b1, 1'b1);
`endif
    chk("lsb_done", done_l, 1'b1);
    chk("lsb_done_ready", ready_l, 1'b1);
    tick();

    // Load while busy is ignored.
    pat = 8'h0F;
    e = 1'b1; d = pat; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin load = 1'b1; d = 8'hFF; end
      else load = 1'b0;
      chk("ign_bit", q_m, pat[7-i]);
      tick();
    end
    load = 1'b0;
`ifdef WORD_SERIAL_TX_PARITY_EN
    end_word(1'b0, 1'b0);
`endif
    chk("ign_done", done_m, 1'b1);
    tick();
    chk("ign_idle", busy_m, 1'b0);

    // Reset mid-word aborts without a done pulse.
    pat = 8'hA5;
    d = pat; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_bit4", q_m, pat[3]);
    r = 1'b1;
    #1;
    chk("abort_q", q_m, 1'b1);
    chk("abort_busy", busy_m, 1'b0);
    chk("abort_ready", ready_m, 1'b1);
    chk("abort_done", done_m, 1'b0);
    r = 1'b0;
    tick();
    chk("abort_no_done1", done_m, 1'b0);
    tick();
    chk("abort_no_done2", done_m, 1'b0);
    chk("abort_idle", busy_m, 1'b0);

    // Back-to-back words with load held high.
    pat = 8'hC3;
    d = pat; load = 1'b1; e = 1'b1;
    tick();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) begin
        chk("b2b_bit", q_m, pat[7-i]);
        chk("b2b_busy", busy_m, 1'b1);
        tick();
      end
`ifdef WORD_SERIAL_TX_PARITY_EN
      end_word(1'b0, 1'b0);
`endif
      chk("b2b_done", done_m, 1'b1);
      chk("b2b_done_q", q_m, 1'b1);
      chk("b2b_ready", ready_m, 1'b1);
      if (w == 1) load = 1'b0;
      tick();
    end
    chk("b2b_final_idle", busy_m, 1'b0);

`ifdef WORD_SERIAL_TX_PARITY_EN
    // Odd-weight word gives parity 1.
    pat = 8'h07;
    d = pat; load = 1'b1; e = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("p07_bit", q_m, pat[7-i]);
      tick();
    end
    end_word(1'b0, 1'b1);
    chk("p07_done", done_m, 1'b1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/word_serial_tx.md
Name: word_serial_tx

Overview:
Parallel-in, serial-out transmitter for a WIDTH-bit word.
- Accepts a word on a load handshake and drives it out one bit per enabled clock on a single line (q, with complement qbar).
- Counterpart to the team's D-latch storage path: the latch captures d under enable; this block plays a captured word back out under the same enable (e) convention.
- Sits between a parallel word source and any single-wire consumer (shift register, LED/probe pin, serial link).

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = bit 0 first.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
r  input  1  reset; asynchronous, active-high.
e  input  1  shift enable; while low, the current bit is held on q.
d  input  WIDTH  parallel word to transmit.
load  input  1  request to accept d (valid).
ready  output  1  high when a load is accepted this cycle (IDLE).
q  output  1  serial data, registered; idles high.
qbar  output  1  always the complement of q.
busy  output  1  high while a word (and optional parity) is being sent.
done  output  1  one-cycle pulse when the final bit period ends.

Behaviour:
- Reset (async, r=1): state=IDLE, shift register=0, bit count=0, q=1, qbar=0, ready=1, busy=0, done=0. Reset asserted mid-word aborts it; no done pulse; after release the block is in IDLE.
- State machine:
  - IDLE: ready=1, busy=0, q=1.
  - IDLE -> SHIFT on load=1 at a clock edge. Acceptance ignores e.
  - On the accept edge: d is captured into the shift register, count=0, and q takes the first bit (d[WIDTH-1] if MSB_FIRST, else d[0]).
  - SHIFT: ready=0, busy=1. Each edge with e=1 ends the current bit period. Each edge with e=0 changes nothing.
  - SHIFT, e=1, count<WIDTH-1: q takes the next bit; count increments.
  - SHIFT, e=1, count==WIDTH-1: go to IDLE (or to PARITY if enabled); q=1; done=1 for exactly one cycle.
- Latency:
  - First bit is valid on q the cycle after acceptance.
  - With e tied high, a word occupies WIDTH cycles and done follows the last bit.
  - The next load is accepted the same cycle done is high, so back-to-back words have zero idle cycles between done and the next first bit.
- Word stability: load while busy is ignored and the word is not queued. d is sampled only on the accept edge; later changes to d have no effect on the word in flight.
- Count: unsigned, width $clog2(WIDTH+1). It never wraps, because the terminal compare ends the word.
- qbar: combinationally ~q at all times, including during reset.

Optional Feature:
Macro: WORD_SERIAL_TX_PARITY_EN.
- Defined:
  - After the last data bit, an extra state PARITY drives q = even parity (XOR of all captured data bits) for one e-qualified bit period.
  - done pulses at the end of PARITY; busy stays high through PARITY.
  - Word length is WIDTH+1 enabled cycles.
- Undefined: PARITY state and its logic are absent; behaviour is exactly as above.

Test Plan:
- Reset values: hold r=1 mid-clock, with no clock edge -> q=1, qbar=0, ready=1, busy=0, done=0 immediately.
- Basic word: WIDTH=8, MSB_FIRST=1, e=1, d=8'hA5, load pulse.
  - Required: q over the next 8 cycles = 1,0,1,0,0,1,0,1.
  - done=1 on the 9th cycle with q=1, ready=1.
- LSB-first and hold: MSB_FIRST=0, d=8'h01, e toggling 1,0,1,0...
  - Required: q=1 held for 2 cycles, then 0 for each later bit period (2 cycles each).
  - done only after the 8th enabled edge.
- Ignored load / reset abort:
  - With d=8'h0F in flight, pulse load with d=8'hFF at bit 3 -> sequence unchanged, 8 bits total.
  - Separate run: assert r at bit 4 -> q=1 and busy=0 at once, no done pulse.
- Back-to-back: hold load=1, d=8'hC3, e=1 -> bits of C3, then the next C3 starting the cycle after done, with no idle-high gap beyond the done cycle.
- Parity (WORD_SERIAL_TX_PARITY_EN defined):
  - d=8'hA5 -> 8 data bits then parity bit 0; done after 9 cycles.
  - d=8'h07 -> parity bit 1.
